// File: rtl/buffer_output_pkg.sv
// ============================================================================
// Module   : buffer_output_pkg
// Brief    : Shared types for the buffer output stage (FSM states, send instr).
// Revision : 1.0
// ============================================================================
`default_nettype none

package buffer_output_pkg;

    localparam int unsigned c_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Default instruction layout; the stage re-declares it at its own ADDR_WIDTH.
    typedef struct packed {
        logic [c_ADDR_WIDTH-1:0] to;
        logic                    pop;
    } send_instr_t;

endpackage

`default_nettype wire

// File: rtl/buffer_output_instr_fifo.sv
// ============================================================================
// Module   : buffer_output_instr_fifo
// Brief    : Synchronous FIFO of send instructions with internal occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module buffer_output_instr_fifo
    import buffer_output_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = send_instr_t
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int unsigned           c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]      c_CNT_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W:0]      c_CNT_FULL = (c_PTR_W+1)'(DEPTH);

    T                 r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_CNT_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/buffer_output_stage.sv
// ============================================================================
// Module   : buffer_output_stage
// Brief    : Drains the head buffer line onto the dtn per queued send instruction.
//            Optional macro BUFFER_OUTPUT_FIFO_BYPASS_EN: empty-FIFO direct issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module buffer_output_stage
    import buffer_output_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instr_to,
    input  logic                  instr_pop,
    input  logic                  instr_valid,
    output logic                  instr_ack,
    input  logic [ADDR_WIDTH-1:0] line_addr,
    input  logic                  line_addr_valid,
    input  logic [DATA_WIDTH-1:0] line_data,
    input  logic                  line_data_valid,
    output logic                  line_ack,
    output logic [ADDR_WIDTH-1:0] dtn_from,
    output logic [ADDR_WIDTH-1:0] dtn_to,
    output logic [DATA_WIDTH-1:0] dtn_data,
    output logic                  dtn_valid,
    input  logic                  dtn_ack
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] to;
        logic                  pop;
    } instr_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_from;
    logic [ADDR_WIDTH-1:0] r_to;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_pop;

    instr_t w_in;
    instr_t w_head;
    instr_t w_sel;
    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_line_ready;
    logic   w_take_fifo;
    logic   w_bypass;
    logic   w_take;

    assign w_in         = '{to: instr_to, pop: instr_pop};
    assign w_line_ready = line_addr_valid & line_data_valid;
    assign instr_ack    = ~w_full & ~reset;
    assign w_take_fifo  = (r_state == IDLE) & ~w_empty & w_line_ready;

`ifdef BUFFER_OUTPUT_FIFO_BYPASS_EN
    assign w_bypass = (r_state == IDLE) & w_empty & instr_valid & w_line_ready;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction is consumed directly and never occupies the queue.
    assign w_push = instr_valid & instr_ack & ~w_bypass;
    assign w_take = w_take_fifo | w_bypass;
    assign w_sel  = w_take_fifo ? w_head : w_in;

    buffer_output_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (instr_t)
    ) u_instr_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_in),
        .pop       (w_take_fifo),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_take)  w_state_next = SEND;
            SEND:    if (dtn_ack) w_state_next = r_pop ? SHIFT : IDLE;
            SHIFT:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_from  <= '0;
            r_to    <= '0;
            r_data  <= '0;
            r_pop   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_from <= line_addr;
                r_data <= line_data;
                r_to   <= w_sel.to;
                r_pop  <= w_sel.pop;
            end
        end
    end

    assign dtn_valid = (r_state == SEND);
    assign line_ack  = (r_state == SHIFT);
    assign dtn_from  = dtn_valid ? r_from : '0;
    assign dtn_to    = r_to;
    assign dtn_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_buffer_output_stage.sv
// ============================================================================
// Module   : tb_buffer_output_stage
// Brief    : Directed table plus hand sequences for buffer_output_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_buffer_output_stage;

`ifdef BUFFER_OUTPUT_FIFO_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  instr_to;
    logic        instr_pop;
    logic        instr_valid;
    logic        instr_ack;
    logic [7:0]  line_addr;
    logic        line_addr_valid;
    logic [31:0] line_data;
    logic        line_data_valid;
    logic        line_ack;
    logic [7:0]  dtn_from;
    logic [7:0]  dtn_to;
    logic [31:0] dtn_data;
    logic        dtn_valid;
    logic        dtn_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    buffer_output_stage #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .instr_to        (instr_to),
        .instr_pop       (instr_pop),
        .instr_valid     (instr_valid),
        .instr_ack       (instr_ack),
        .line_addr       (line_addr),
        .line_addr_valid (line_addr_valid),
        .line_data       (line_data),
        .line_data_valid (line_data_valid),
        .line_ack        (line_ack),
        .dtn_from        (dtn_from),
        .dtn_to          (dtn_to),
        .dtn_data        (dtn_data),
        .dtn_valid       (dtn_valid),
        .dtn_ack         (dtn_ack)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [7:0]  ito;
        logic        ipop;
        logic        lav;
        logic        ldv;
        logic [7:0]  la;
        logic [31:0] ld;
        logic        ack;
        logic        e_iack;
        logic        e_dv;
        logic        e_lack;
        logic [7:0]  e_from;
        logic [7:0]  e_to;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [7:0] ito, input logic ipop,
                         input logic lav, input logic ldv, input logic [7:0] la,
                         input logic [31:0] ld, input logic ack);
        reset           = rst;
        instr_valid     = iv;
        instr_to        = ito;
        instr_pop       = ipop;
        line_addr_valid = lav;
        line_data_valid = ldv;
        line_addr       = la;
        line_data       = ld;
        dtn_ack         = ack;
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] ito,
                                input logic ipop, input logic lav, input logic ldv,
                                input logic [7:0] la, input logic [31:0] ld, input logic ack,
                                input logic e_iack, input logic e_dv, input logic e_lack,
                                input logic [7:0] e_from, input logic [7:0] e_to,
                                input logic [31:0] e_data);
        vec_t v;
        v = '{rst, iv, ito, ipop, lav, ldv, la, ld, ack, e_iack, e_dv, e_lack, e_from, e_to, e_data};
        return v;
    endfunction

    localparam logic [7:0]  H1 = 8'h05;
    localparam logic [31:0] D1 = 32'hDEADBEEF;
    localparam logic [7:0]  H2 = 8'h06;
    localparam logic [31:0] D2 = 32'h12345678;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single send with pop; an instruction offered during reset must be dropped.
        vq.push_back(mk(1, 1, 8'h77, 1, 1, 1, H1, D1, 1,  0, 0, 0, 0,  0,     0));
        vq.push_back(mk(0, 1, 8'h11, 1, 1, 1, H1, D1, 1,  1, 0, 0, 0,  0,     0));
`ifdef BUFFER_OUTPUT_FIFO_BYPASS_EN
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 1, 0, H1, 8'h11, D1));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 1, 0,  0,     0));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 0, 0,  0,     0));
`else
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 0, 0,  0,     0));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 1, 0, H1, 8'h11, D1));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 1, 0,  0,     0));
`endif
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 0, 0,  0,     0));
        // Three sends from the same head, pop only on the last.
        vq.push_back(mk(0, 1, 8'h11, 0, 1, 0, H1, D1, 1,  1, 0, 0, 0,  0,     0));
        vq.push_back(mk(0, 1, 8'h12, 0, 1, 1, H1, D1, 1,  1, 0, 0, 0,  0,     0));
        vq.push_back(mk(0, 1, 8'h13, 1, 1, 1, H1, D1, 1,  1, 1, 0, H1, 8'h11, D1));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 0, 0,  0,     0));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 1, 0, H1, 8'h12, D1));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 0, 0,  0,     0));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 1, 0, H1, 8'h13, D1));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 1, 0,  0,     0));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H1, D1, 1,  1, 0, 0, 0,  0,     0));
        // Backpressure: ack held low for 5 SEND cycles, then accepted.
        vq.push_back(mk(0, 1, 8'h21, 1, 1, 0, H2, D2, 0,  1, 0, 0, 0,  0,     0));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H2, D2, 0,  1, 0, 0, 0,  0,     0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H2, D2, 0,  1, 1, 0, H2, 8'h21, D2));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H2, D2, 1,  1, 1, 0, H2, 8'h21, D2));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H2, D2, 1,  1, 0, 1, 0,  0,     0));
        vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, H2, D2, 1,  1, 0, 0, 0,  0,     0));

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].iv, vq[i].ito, vq[i].ipop, vq[i].lav, vq[i].ldv,
                  vq[i].la, vq[i].ld, vq[i].ack);
            check($sformatf("v%0d.instr_ack", i), 32'(instr_ack), 32'(vq[i].e_iack));
            check($sformatf("v%0d.dtn_valid", i), 32'(dtn_valid), 32'(vq[i].e_dv));
            check($sformatf("v%0d.line_ack", i),  32'(line_ack),  32'(vq[i].e_lack));
            check($sformatf("v%0d.dtn_from", i),  32'(dtn_from),  32'(vq[i].e_from));
            if (vq[i].e_dv) begin
                check($sformatf("v%0d.dtn_to", i),   32'(dtn_to), 32'(vq[i].e_to));
                check($sformatf("v%0d.dtn_data", i), dtn_data,    vq[i].e_data);
            end
            tick();
        end

        // Fill the queue while the head has no data: 4 accepted, 5th refused.
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 8'(8'h31 + k), 0, 1, 0, H2, D2, 1);
            check($sformatf("full.k%0d.instr_ack", k), 32'(instr_ack), (k < 4) ? 32'd1 : 32'd0);
            check($sformatf("full.k%0d.dtn_valid", k), 32'(dtn_valid), 32'd0);
            tick();
        end
        drive(0, 0, 8'h00, 0, 1, 1, H2, D2, 1);
        check("drain.d0.instr_ack", 32'(instr_ack), 32'd0);
        check("drain.d0.dtn_valid", 32'(dtn_valid), 32'd0);
        tick();
        for (int j = 0; j < 10; j++) begin
            check($sformatf("drain.d%0d.dtn_valid", j + 1), 32'(dtn_valid),
                  (j < 8 && j % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("drain.d%0d.instr_ack", j + 1), 32'(instr_ack), 32'd1);
            check($sformatf("drain.d%0d.line_ack", j + 1),  32'(line_ack),  32'd0);
            if (j < 8 && j % 2 == 0)
                check($sformatf("drain.d%0d.dtn_to", j + 1), 32'(dtn_to), 32'(8'h31 + j / 2));
            tick();
        end

        // Reset in SEND with a pending pop and one more queued instruction.
        drive(0, 1, 8'h41, 1, 1, 0, H2, D2, 0);
        check("rst.a0.instr_ack", 32'(instr_ack), 32'd1);
        tick();
        drive(0, 1, 8'h42, 0, 1, 1, H2, D2, 0);
        check("rst.a1.dtn_valid", 32'(dtn_valid), 32'd0);
        tick();
        drive(1, 0, 8'h00, 0, 1, 1, H2, D2, 0);
        check("rst.a2.dtn_valid", 32'(dtn_valid), 32'd1);
        check("rst.a2.dtn_to",    32'(dtn_to),    32'h41);
        check("rst.a2.instr_ack", 32'(instr_ack), 32'd0);
        tick();
        drive(0, 0, 8'h00, 0, 1, 1, H2, D2, 1);
        for (int k = 3; k < 6; k++) begin
            check($sformatf("rst.a%0d.dtn_valid", k), 32'(dtn_valid), 32'd0);
            check($sformatf("rst.a%0d.line_ack", k),  32'(line_ack),  32'd0);
            check($sformatf("rst.a%0d.dtn_from", k),  32'(dtn_from),  32'd0);
            tick();
        end

        // Instruction-to-message latency with an empty queue and a ready head.
        drive(0, 1, 8'h51, 0, 1, 1, 8'h07, 32'hCAFEF00D, 1);
        check("lat.n0.instr_ack", 32'(instr_ack), 32'd1);
        tick();
        drive(0, 0, 8'h00, 0, 1, 1, 8'h07, 32'hCAFEF00D, 1);
        check("lat.n1.dtn_valid", 32'(dtn_valid), c_BYPASS ? 32'd1 : 32'd0);
        tick();
        check("lat.n2.dtn_valid", 32'(dtn_valid), c_BYPASS ? 32'd0 : 32'd1);
        if (!c_BYPASS) begin
            check("lat.n2.dtn_to",   32'(dtn_to),   32'h51);
            check("lat.n2.dtn_from", 32'(dtn_from), 32'h07);
            check("lat.n2.dtn_data", dtn_data,      32'hCAFEF00D);
        end
        tick();
        check("lat.n3.dtn_valid", 32'(dtn_valid), 32'd0);
        check("lat.n3.line_ack",  32'(line_ack),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
